// File: rtl/sel_priority_encoder_pkg.sv
// Shared types and helpers for the vending-machine selection encoder.
// Holds the FSM state type, the input-count ceiling and the highest-set-bit helper.
package vm_pkg;

  localparam int unsigned MAX_SEL_IN = 32;
  localparam int unsigned MAX_CODE_W = $clog2(MAX_SEL_IN);

  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } sel_state_e;

  // Later (higher) indices overwrite earlier ones, so the result is the top set bit.
  function automatic logic [MAX_CODE_W-1:0] highest_set(input logic [MAX_SEL_IN-1:0] v);
    highest_set = '0;
    for (int unsigned i = 0; i < MAX_SEL_IN; i++) begin
      if (v[i]) highest_set = MAX_CODE_W'(i);
    end
  endfunction

endpackage

// File: rtl/sel_priority_encoder_debounce.sv
// Single-bit 2-FF synchroniser followed by a stability counter.
// o_level follows the synchronised input only after DEB_CYCLES identical samples.
module sel_debounce #(
  parameter int unsigned DEB_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_din,
  output logic o_level
);

  localparam int unsigned CNT_W = (DEB_CYCLES < 2) ? 1 : $clog2(DEB_CYCLES + 1);

  logic [1:0]       r_sync;
  logic [CNT_W-1:0] r_cnt;
  logic             r_level;

  // Counter tracks how long the synchronised sample has disagreed with the filtered level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync  <= '0;
      r_cnt   <= '0;
      r_level <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], i_din};
      if (r_sync[1] == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_W'(DEB_CYCLES - 1)) begin
        r_level <= r_sync[1];
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_level = r_level;

endmodule

// File: rtl/sel_priority_encoder.sv
// Registered priority encoder: sticky button requests issued highest-index first via valid/ack.
// Optional input debounce enabled by defining SEL_ENC_DEBOUNCE_EN.
module sel_priority_encoder
  import vm_pkg::*;
#(
  parameter  int unsigned N_IN       = 8,
  parameter  int unsigned DEB_CYCLES = 4,
  localparam int unsigned CODE_W     = $clog2(N_IN)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              flush,
  input  logic [N_IN-1:0]   sel_in,
  output logic [CODE_W-1:0] sel_code,
  output logic              sel_valid,
  input  logic              sel_ack,
  output logic [N_IN-1:0]   pending,
  output logic              none
);

  if (N_IN < 2 || N_IN > MAX_SEL_IN) begin : g_bad_n_in
    $error("sel_priority_encoder: N_IN out of range 2..32");
  end
  if (DEB_CYCLES < 1) begin : g_bad_deb
    $error("sel_priority_encoder: DEB_CYCLES must be at least 1");
  end

  logic [N_IN-1:0]   w_level;
  logic [N_IN-1:0]   w_rise;
  logic [N_IN-1:0]   r_hist;
  logic [N_IN-1:0]   r_pending;
  logic [N_IN-1:0]   w_pending_nxt;
  logic [CODE_W-1:0] r_code;
  logic [CODE_W-1:0] w_code_nxt;
  logic              r_valid;
  logic              w_valid_nxt;
  sel_state_e        r_state;
  sel_state_e        w_state_nxt;

`ifdef SEL_ENC_DEBOUNCE_EN
  for (genvar gi = 0; gi < N_IN; gi++) begin : g_deb
    sel_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_din   (sel_in[gi]),
      .o_level (w_level[gi])
    );
  end
`else
  assign w_level = sel_in;
`endif

  assign w_rise = w_level & ~r_hist & {N_IN{enable}};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_hist <= '0;
    else        r_hist <= w_level;
  end

  // Ack clears before capture is OR-ed in, so a coincident re-press keeps its bit set.
  always_comb begin
    w_state_nxt   = r_state;
    w_code_nxt    = r_code;
    w_valid_nxt   = r_valid;
    w_pending_nxt = r_pending;
    if (flush) begin
      w_state_nxt   = IDLE;
      w_code_nxt    = '0;
      w_valid_nxt   = 1'b0;
      w_pending_nxt = '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (enable && (r_pending != '0)) begin
            w_code_nxt  = CODE_W'(highest_set(MAX_SEL_IN'(r_pending)));
            w_valid_nxt = 1'b1;
            w_state_nxt = PRESENT;
          end
        end
        PRESENT: begin
          if (sel_ack) begin
            w_pending_nxt[r_code] = 1'b0;
            w_valid_nxt           = 1'b0;
            w_state_nxt           = IDLE;
          end
        end
        default: w_state_nxt = IDLE;
      endcase
      w_pending_nxt = w_pending_nxt | w_rise;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_code    <= '0;
      r_valid   <= 1'b0;
      r_pending <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_code    <= w_code_nxt;
      r_valid   <= w_valid_nxt;
      r_pending <= w_pending_nxt;
    end
  end

  assign sel_code  = r_code;
  assign sel_valid = r_valid;
  assign pending   = r_pending;
  assign none      = (r_pending == '0) && !r_valid;

endmodule
